fifo_sync_prog: RTL and testbench

FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_dp_ram.sv | 44 ++++
 rtl/fifo_sync_prog.sv | 156 +++++++++++++++
 tb/tb_fifo_sync_prog.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and flag constants for the programmable FIFO.
// Count width is one bit wider than the pointer so a full FIFO is representable.
package fifo_pkg;

    localparam int FIFO_CNT_EMPTY = 0;

    function automatic int fifo_cnt_w(input int depth_bits);
        return depth_bits + 1;
    endfunction

    function automatic int fifo_depth(input int depth_bits);
        return 1 << depth_bits;
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Read register only loads on a read so its output holds between pops.
module fifo_dp_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-empty/full thresholds and sticky errors.
// Define FIFO_SYNC_PROG_PEAK_EN to enable the peak fill-level tracker.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int DEPTH_BITS = 4,
    parameter int WIDTH_BITS = 8,
    localparam int CW = fifo_cnt_w(DEPTH_BITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  a_push_en,
    input  logic [WIDTH_BITS-1:0] a_di,
    input  logic                  b_pop_en,
    output logic [WIDTH_BITS-1:0] b_do,
    output logic                  b_rdy,
    input  logic [CW-1:0]         ae_thresh,
    input  logic [CW-1:0]         af_thresh,
    output logic [CW-1:0]         fill_cnt,
    output logic                  flag_empty,
    output logic                  flag_almost_empty,
    output logic                  flag_almost_full,
    output logic                  flag_full,
    output logic                  flag_overflow,
    output logic                  flag_underflow,
    output logic [CW-1:0]         peak_cnt,
    input  logic                  peak_clr
);

    localparam int DEPTH = fifo_depth(DEPTH_BITS);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = CW'(FIFO_CNT_EMPTY);

    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rdy_q, rdy_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  ram_we;
    logic                  ram_re;

    // A pop frees a slot in the same cycle, so push at full is legal alongside it.
    always_comb begin
        pop_ok  = b_pop_en && (cnt_q != CNT_EMPTY);
        push_ok = a_push_en && ((cnt_q != CNT_FULL) || pop_ok);
        ram_we  = push_ok && !flush;
        ram_re  = pop_ok && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rdy_d    = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            rdy_d = pop_ok;
            ovf_d = ovf_q | (a_push_en & ~push_ok);
            udf_d = udf_q | (b_pop_en & ~pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_dp_ram #(
        .AW(DEPTH_BITS),
        .DW(WIDTH_BITS)
    ) u_ram (
        .clk  (clk),
        .rst_n(reset),
        .we   (ram_we),
        .waddr(wr_ptr_q),
        .wdata(a_di),
        .re   (ram_re),
        .raddr(rd_ptr_q),
        .rdata(b_do)
    );

    assign b_rdy             = rdy_q;
    assign fill_cnt          = cnt_q;
    assign flag_empty        = (cnt_q == CNT_EMPTY);
    assign flag_full         = (cnt_q == CNT_FULL);
    assign flag_almost_empty = (cnt_q <= ae_thresh);
    assign flag_almost_full  = (cnt_q >= af_thresh);
    assign flag_overflow     = ovf_q;
    assign flag_underflow    = udf_q;

`ifdef FIFO_SYNC_PROG_PEAK_EN
    logic [CW-1:0] peak_q, peak_d;

    // Clear loads the post-edge level so the tracker restarts from "now".
    always_comb begin
        peak_d = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (peak_clr) begin
            peak_d = cnt_d;
        end else if (cnt_d > peak_q) begin
            peak_d = cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_cnt = peak_q;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: vector table plus data scoreboard.
// Peak-tracker checks follow FIFO_SYNC_PROG_PEAK_EN.
module tb_fifo_sync_prog;

    localparam int DB    = 4;
    localparam int WB    = 8;
    localparam int CW    = 5;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          a_push_en;
    logic [WB-1:0] a_di;
    logic          b_pop_en;
    logic [WB-1:0] b_do;
    logic          b_rdy;
    logic [CW-1:0] ae_thresh;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] fill_cnt;
    logic          flag_empty;
    logic          flag_almost_empty;
    logic          flag_almost_full;
    logic          flag_full;
    logic          flag_overflow;
    logic          flag_underflow;
    logic [CW-1:0] peak_cnt;
    logic          peak_clr;

    fifo_sync_prog #(
        .DEPTH_BITS(DB),
        .WIDTH_BITS(WB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .a_push_en        (a_push_en),
        .a_di             (a_di),
        .b_pop_en         (b_pop_en),
        .b_do             (b_do),
        .b_rdy            (b_rdy),
        .ae_thresh        (ae_thresh),
        .af_thresh        (af_thresh),
        .fill_cnt         (fill_cnt),
        .flag_empty       (flag_empty),
        .flag_almost_empty(flag_almost_empty),
        .flag_almost_full (flag_almost_full),
        .flag_full        (flag_full),
        .flag_overflow    (flag_overflow),
        .flag_underflow   (flag_underflow),
        .peak_cnt         (peak_cnt),
        .peak_clr         (peak_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit            push;
        bit            pop;
        logic [WB-1:0] din;
        int            cnt;
        bit            ae;
        bit            af;
        bit            full;
        bit            empty;
    } vec_t;

    vec_t          tbl[32];
    int            total = 0;
    int            bad   = 0;
    logic [WB-1:0] mq[$];
    logic [WB-1:0] exp_q[$];
    int            mcnt  = 0;
    int            mpeak = 0;
    bit            movf  = 0;
    bit            mudf  = 0;
    bit            exp_rdy = 0;
    logic [WB-1:0] mlast = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        mcnt    = 0;
        movf    = 0;
        mudf    = 0;
        mpeak   = 0;
        exp_rdy = 0;
    endtask

    task automatic step(input bit push, input bit pop, input logic [WB-1:0] din,
                        input bit fl, input bit pclr);
        bit pop_ok;
        bit push_ok;
        @(negedge clk);
        a_push_en = push;
        b_pop_en  = pop;
        a_di      = din;
        flush     = fl;
        peak_clr  = pclr;
        pop_ok  = pop && (mcnt > 0);
        push_ok = push && ((mcnt < DEPTH) || pop_ok);
        exp_rdy = 0;
        if (fl) begin
            model_clear();
        end else begin
            if (push && !push_ok) movf = 1;
            if (pop && !pop_ok) mudf = 1;
            if (pop_ok) begin
                exp_q.push_back(mq.pop_front());
                exp_rdy = 1;
            end
            if (push_ok) mq.push_back(din);
            mcnt = mq.size();
`ifdef FIFO_SYNC_PROG_PEAK_EN
            if (pclr) mpeak = mcnt;
            else if (mcnt > mpeak) mpeak = mcnt;
`endif
        end
        @(posedge clk);
        #1;
        a_push_en = 0;
        b_pop_en  = 0;
        flush     = 0;
        peak_clr  = 0;
        chk("b_rdy", b_rdy, exp_rdy);
        if (b_rdy) begin
            if (exp_q.size() == 0) begin
                chk("b_do_unexpected", 1, 0);
            end else begin
                mlast = exp_q.pop_front();
                chk("b_do", b_do, mlast);
            end
        end else begin
            chk("b_do_hold", b_do, mlast);
        end
        chk("fill_cnt", fill_cnt, mcnt);
        chk("empty", flag_empty, mcnt == 0);
        chk("full", flag_full, mcnt == DEPTH);
        chk("almost_empty", flag_almost_empty, mcnt <= int'(ae_thresh));
        chk("almost_full", flag_almost_full, mcnt >= int'(af_thresh));
        chk("overflow", flag_overflow, movf);
        chk("underflow", flag_underflow, mudf);
        chk("peak_cnt", peak_cnt, mpeak);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{1'b1, 1'b0, 8'(i + 1), i + 1, (i + 1) <= 2,
                       (i + 1) >= 14, (i + 1) == 16, 1'b0};
        end
        for (int i = 0; i < 16; i++) begin
            tbl[16 + i] = '{1'b0, 1'b1, 8'h00, 15 - i, (15 - i) <= 2,
                            (15 - i) >= 14, 1'b0, (15 - i) == 0};
        end

        reset     = 1'b0;
        flush     = 1'b0;
        a_push_en = 1'b0;
        a_di      = '0;
        b_pop_en  = 1'b0;
        peak_clr  = 1'b0;
        ae_thresh = 5'd2;
        af_thresh = 5'd14;
        #12;
        chk("rst_cnt", fill_cnt, 0);
        chk("rst_empty", flag_empty, 1);
        chk("rst_full", flag_full, 0);
        chk("rst_rdy", b_rdy, 0);
        chk("rst_do", b_do, 0);
        chk("rst_ovf", flag_overflow, 0);
        chk("rst_udf", flag_underflow, 0);
        chk("rst_peak", peak_cnt, 0);
        @(negedge clk);
        reset = 1'b1;

        // fill 16 then drain 16 with threshold flags
        for (int i = 0; i < 32; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].din, 1'b0, 1'b0);
            chk("tbl_cnt", fill_cnt, tbl[i].cnt);
            chk("tbl_ae", flag_almost_empty, tbl[i].ae);
            chk("tbl_af", flag_almost_full, tbl[i].af);
            chk("tbl_full", flag_full, tbl[i].full);
            chk("tbl_empty", flag_empty, tbl[i].empty);
            chk("tbl_ovf", flag_overflow, 0);
        end

        // overflow at full, then push+pop at full
        for (int i = 0; i < 16; i++) step(1, 0, 8'h40 + 8'(i), 0, 0);
        step(1, 0, 8'hAA, 0, 0);
        chk("ovf17_flag", flag_overflow, 1);
        chk("ovf17_cnt", fill_cnt, 16);
        step(1, 1, 8'hBB, 0, 0);
        chk("full_pp_cnt", fill_cnt, 16);
        chk("full_pp_data", b_do, 8'h40);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 0);
        chk("drain_last", b_do, 8'hBB);
        step(0, 0, 8'h00, 1, 0);
        chk("flush_ovf", flag_overflow, 0);

        // pop+push on empty
        step(1, 1, 8'h55, 0, 0);
        chk("udf_flag", flag_underflow, 1);
        chk("udf_cnt", fill_cnt, 1);
        chk("udf_rdy", b_rdy, 0);
        step(0, 0, 8'h00, 1, 0);

        // pointer wrap with streaming traffic, then flush under push
        step(0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 40; i++) step(1, i >= 3, 8'h20 + 8'(i), 0, 0);
        step(1, 1, 8'hEE, 1, 0);
        chk("flush_cnt", fill_cnt, 0);
        chk("flush_udf", flag_underflow, 0);
        chk("flush_rdy", b_rdy, 0);
        step(0, 0, 8'h00, 0, 0);

`ifdef FIFO_SYNC_PROG_PEAK_EN
        for (int i = 0; i < 9; i++) step(1, 0, 8'h70 + 8'(i), 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 8'h00, 0, 0);
        chk("peak_9", peak_cnt, 9);
        step(0, 0, 8'h00, 0, 1);
        chk("peak_clr", peak_cnt, 3);
`else
        for (int i = 0; i < 3; i++) step(1, 0, 8'h70 + 8'(i), 0, 1);
        chk("peak_off", peak_cnt, 0);
`endif

        // asynchronous reset in the middle of an accepted pop
        @(negedge clk);
        b_pop_en = 1'b1;
        #2;
        reset = 1'b0;
        model_clear();
        mlast = '0;
        #1;
        chk("mid_rst_cnt", fill_cnt, 0);
        chk("mid_rst_rdy", b_rdy, 0);
        chk("mid_rst_do", b_do, 0);
        chk("mid_rst_peak", peak_cnt, 0);
        chk("mid_rst_empty", flag_empty, 1);
        @(negedge clk);
        b_pop_en = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_rdy", b_rdy, 0);
        end
        step(0, 0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
